// File: rtl/sync_fifo_flags.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sync_fifo_flags
// Purpose  : Single-clock FIFO with almost-full/almost-empty thresholds,
//            occupancy count, sticky overflow/underflow and optional FWFT read.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_flags #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int PTR_WIDTH     = $clog2(DEPTH),
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4,
    parameter int FWFT          = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    count,
    output logic [PTR_WIDTH:0]    w_ptr,
    output logic [PTR_WIDTH:0]    r_ptr,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam logic [PTR_WIDTH:0] C_PTR_ONE = (PTR_WIDTH+1)'(1);
    localparam logic [PTR_WIDTH:0] C_AFULL   = (PTR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [PTR_WIDTH:0] C_AEMPTY  = (PTR_WIDTH+1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_WIDTH:0]    r_wr_ptr;
    logic [PTR_WIDTH:0]    r_rd_ptr;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic [PTR_WIDTH:0]    w_count;
    logic                  w_wr_ok;
    logic                  w_rd_ok;

    // Flags derive only from registered pointers, never from the requests.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_WIDTH] != r_rd_ptr[PTR_WIDTH]) &&
                     (r_wr_ptr[PTR_WIDTH-1:0] == r_rd_ptr[PTR_WIDTH-1:0]);
    assign w_count = r_wr_ptr - r_rd_ptr;

    assign w_wr_ok = w_en && !w_full;
    assign w_rd_ok = r_en && !w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr[PTR_WIDTH-1:0]] <= w_data;
        end
    end

    // A fresh error event outranks a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_en && w_full) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (r_en && w_empty) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [DATA_WIDTH-1:0] r_rd_data;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rd_data <= '0;
                end else if (w_rd_ok) begin
                    r_rd_data <= r_mem[r_rd_ptr[PTR_WIDTH-1:0]];
                end
            end

            assign r_data = r_rd_data;
        end else begin : g_fwft_read
            // Head word is presented as soon as the FIFO is non-empty.
            assign r_data = w_empty ? '0 : r_mem[r_rd_ptr[PTR_WIDTH-1:0]];
        end
    endgenerate

    assign full         = w_full;
    assign empty        = w_empty;
    assign count        = w_count;
    assign almost_full  = (w_count >= C_AFULL);
    assign almost_empty = (w_count <= C_AEMPTY);
    assign w_ptr        = r_wr_ptr;
    assign r_ptr        = r_rd_ptr;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire
